// File: rtl/hsi_com_rx.sv
// Receive-side HSI deserializer: recovers odd-parity bytes from redundant lines com1/com2 and groups them into CCWs.
// Define HSI_RX_MAJORITY_EN for 2-of-3 majority bit sampling; default build uses one centre sample.
module hsi_com_rx #(
    parameter int OVS          = 48,
    parameter int WORD_BYTES   = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       com1,
    input  logic       com2,
    output logic [7:0] q,
    output logic       q_rdy,
    output logic       ccw_accepted,
    output logic       ccw_repeat_req,
    output logic       frame_err,
    output logic       busy,
    output logic       chan
);
    localparam int TW = $clog2(OVS + 1);
    localparam int GW = $clog2(TIMEOUT_BITS * OVS);
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [TW-1:0] T_HALF  = TW'(OVS / 2);
    localparam logic [TW-1:0] T_FULL  = TW'(OVS);
    localparam logic [TW-1:0] T_FLUSH = TW'(OVS - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(TIMEOUT_BITS * OVS - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_FLUSH
    } state_t;

    state_t      state;
    logic [1:0]  com1_sync, com2_sync;
    logic        com1_d, com2_d;
    logic        com1_s, com2_s;
    logic        fall1, fall2, line, line_fall, vote;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;
    logic [BW-1:0] byte_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par;

    assign com1_s    = com1_sync[1];
    assign com2_s    = com2_sync[1];
    assign fall1     = com1_d & ~com1_s;
    assign fall2     = com2_d & ~com2_s;
    assign line      = chan ? com2_s : com1_s;
    assign line_fall = chan ? fall2 : fall1;

    // Synchronizers reset to the idle-high level so release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com1_sync <= 2'b11;
            com2_sync <= 2'b11;
            com1_d    <= 1'b1;
            com2_d    <= 1'b1;
        end else begin
            com1_sync <= {com1_sync[0], com1};
            com2_sync <= {com2_sync[0], com2};
            com1_d    <= com1_s;
            com2_d    <= com2_s;
        end
    end

    // Bit decisions are taken at centre+1 in both builds so latency does not depend on the vote mode.
`ifdef HSI_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], line};
    end
    assign vote = (hist[1] & hist[0]) | (hist[1] & line) | (hist[0] & line);
`else
    logic hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= 1'b1;
        else     hist <= line;
    end
    assign vote = hist;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            q              <= 8'h00;
            q_rdy          <= 1'b0;
            ccw_accepted   <= 1'b0;
            ccw_repeat_req <= 1'b0;
            frame_err      <= 1'b0;
            busy           <= 1'b0;
            chan           <= 1'b0;
            timer          <= '0;
            gap_cnt        <= '0;
            byte_cnt       <= '0;
            bit_cnt        <= '0;
            shift          <= 8'h00;
            par            <= 1'b0;
        end else begin
            q_rdy          <= 1'b0;
            ccw_accepted   <= 1'b0;
            ccw_repeat_req <= 1'b0;
            frame_err      <= 1'b0;
            if (!en) begin
                state    <= S_IDLE;
                byte_cnt <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (fall1 || fall2) begin
                            chan  <= ~fall1;
                            state <= S_START;
                            timer <= T_ONE;
                            busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (timer == T_HALF) begin
                            timer <= T_ONE;
                            if (vote) begin
                                state    <= S_IDLE;
                                busy     <= 1'b0;
                                byte_cnt <= '0;
                            end else begin
                                state   <= S_DATA;
                                bit_cnt <= '0;
                            end
                        end else begin
                            timer <= timer + T_ONE;
                        end
                    end
                    S_DATA: begin
                        if (timer == T_FULL) begin
                            timer <= T_ONE;
                            shift <= {vote, shift[7:1]};
                            if (bit_cnt == 3'd7) state <= S_PARITY;
                            else                 bit_cnt <= bit_cnt + 3'd1;
                        end else begin
                            timer <= timer + T_ONE;
                        end
                    end
                    S_PARITY: begin
                        if (timer == T_FULL) begin
                            timer <= T_ONE;
                            par   <= vote;
                            state <= S_STOP;
                        end else begin
                            timer <= timer + T_ONE;
                        end
                    end
                    S_STOP: begin
                        if (timer == T_FULL) begin
                            timer <= '0;
                            if (vote && (^{par, shift})) begin
                                q     <= shift;
                                q_rdy <= 1'b1;
                                if (byte_cnt == B_LAST) begin
                                    ccw_accepted <= 1'b1;
                                    byte_cnt     <= '0;
                                    state        <= S_IDLE;
                                    busy         <= 1'b0;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                    gap_cnt  <= '0;
                                    state    <= S_GAP;
                                end
                            end else begin
                                frame_err      <= 1'b1;
                                ccw_repeat_req <= 1'b1;
                                byte_cnt       <= '0;
                                state          <= S_FLUSH;
                            end
                        end else begin
                            timer <= timer + T_ONE;
                        end
                    end
                    S_GAP: begin
                        if (line_fall) begin
                            state <= S_START;
                            timer <= T_ONE;
                        end else if (gap_cnt == G_LAST) begin
                            ccw_repeat_req <= 1'b1;
                            byte_cnt       <= '0;
                            state          <= S_IDLE;
                            busy           <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        // Only a full bit-time of idle line ends the flush; no resync inside a byte.
                        if (!line) begin
                            timer <= '0;
                        end else if (timer == T_FLUSH) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            timer <= timer + T_ONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hsi_com_rx.sv
// Directed self-checking bench for hsi_com_rx: CCW reception, parity error, timeout, glitch, dual-line start, enable abort, reset.
`timescale 1ns/1ps
module tb_hsi_com_rx;
    localparam int OVS = 48;
    localparam int WB  = 4;
    localparam int TOB = 20;
    localparam logic [10:0] IDLE_FRAME = 11'h7FF;

    logic       clk = 1'b0;
    logic       rst, en, com1, com2;
    logic [7:0] q;
    logic       q_rdy, ccw_accepted, ccw_repeat_req, frame_err, busy, chan;

    always #5 clk = ~clk;

    hsi_com_rx #(.OVS(OVS), .WORD_BYTES(WB), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .rst(rst), .en(en), .com1(com1), .com2(com2),
        .q(q), .q_rdy(q_rdy), .ccw_accepted(ccw_accepted),
        .ccw_repeat_req(ccw_repeat_req), .frame_err(frame_err),
        .busy(busy), .chan(chan)
    );

    int checks = 0;
    int failures = 0;
    int rx_n = 0, acc_n = 0, rep_n = 0, ferr_n = 0, acc_rdy_n = 0, ferr_rep_n = 0;
    logic [7:0] rx_bytes [0:255];

    always @(negedge clk) begin
        if (q_rdy && rx_n < 256) begin
            rx_bytes[rx_n] = q;
            rx_n++;
            $display("[%0t] rx byte %02h chan=%0d", $time, q, chan);
        end
        if (ccw_accepted) begin
            acc_n++;
            if (q_rdy) acc_rdy_n++;
            $display("[%0t] ccw accepted", $time);
        end
        if (ccw_repeat_req) begin
            rep_n++;
            if (frame_err) ferr_rep_n++;
            $display("[%0t] ccw repeat request frame_err=%0d", $time, frame_err);
        end
        if (frame_err) ferr_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_ok);
        logic p;
        p = par_ok ? ~(^d) : (^d);
        return {1'b1, p, d, 1'b0};
    endfunction

    // One bit-time on both lines; optional 1-clk inversion of com1 at the receiver's centre sample.
    task automatic drive_bit(input logic b1, input logic b2, input logic glitch);
        com1 = b1;
        com2 = b2;
        if (glitch) begin
            repeat (22) @(negedge clk);
            com1 = ~b1;
            @(negedge clk);
            com1 = b1;
            repeat (OVS - 23) @(negedge clk);
        end else begin
            repeat (OVS) @(negedge clk);
        end
    endtask

    task automatic send_frames(input logic [10:0] f1, input logic [10:0] f2,
                               input int idle_bits, input logic glitch);
        for (int i = 0; i < 11; i++) drive_bit(f1[i], f2[i], glitch);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_bytes(input string tag, input int first, input logic [7:0] e [4]);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_byte%0d", tag, i), {24'h0, rx_bytes[first + i]}, {24'h0, e[i]});
    endtask

    logic [7:0] ccw1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] ccw2 [4] = '{8'h5A, 8'hC3, 8'h00, 8'hFF};
    logic [7:0] ccw5 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] gar5 [4] = '{8'hFF, 8'h00, 8'h3C, 8'h96};
    logic [7:0] ccw6 [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
    logic [7:0] ccw7 [4] = '{8'h55, 8'hAA, 8'h0F, 8'hF0};

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, a0, p0, f0, ar0, fr0;
        logic [10:0] fr;
        rst = 1'b1; en = 1'b1; com1 = 1'b1; com2 = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_q", {24'h0, q}, 32'h0);
        check("reset_q_rdy", {31'h0, q_rdy}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_chan", {31'h0, chan}, 32'h0);
        check("reset_accepted", {31'h0, ccw_accepted}, 32'h0);
        check("reset_repeat", {31'h0, ccw_repeat_req}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        repeat (OVS) @(negedge clk);

        // Test 1: valid CCW on com1
        r0 = rx_n; a0 = acc_n; p0 = rep_n; ar0 = acc_rdy_n;
        for (int i = 0; i < 4; i++) send_frames(mk_frame(ccw1[i], 1'b1), IDLE_FRAME, 1, 1'b0);
        check("t1_rx_count", rx_n - r0, 4);
        check_bytes("t1", r0, ccw1);
        check("t1_accepted", acc_n - a0, 1);
        check("t1_accept_with_rdy", acc_rdy_n - ar0, 1);
        check("t1_repeat", rep_n - p0, 0);
        check("t1_chan", {31'h0, chan}, 0);
        check("t1_busy", {31'h0, busy}, 0);
        check("t1_q_held", {24'h0, q}, 32'h44);

        // Test 2: bad parity on com2, then valid CCW on com2
        r0 = rx_n; a0 = acc_n; p0 = rep_n; f0 = ferr_n; fr0 = ferr_rep_n;
        send_frames(IDLE_FRAME, mk_frame(8'hA5, 1'b0), 1, 1'b0);
        check("t2_no_rdy", rx_n - r0, 0);
        check("t2_frame_err", ferr_n - f0, 1);
        check("t2_repeat", rep_n - p0, 1);
        check("t2_ferr_with_repeat", ferr_rep_n - fr0, 1);
        check("t2_chan", {31'h0, chan}, 1);
        check("t2_busy_after_flush", {31'h0, busy}, 0);
        r0 = rx_n; a0 = acc_n;
        for (int i = 0; i < 4; i++) send_frames(IDLE_FRAME, mk_frame(ccw2[i], 1'b1), 1, 1'b0);
        check("t2_rx_count", rx_n - r0, 4);
        check_bytes("t2", r0, ccw2);
        check("t2_accepted", acc_n - a0, 1);

        // Test 3: two bytes then inter-byte timeout
        r0 = rx_n; a0 = acc_n; p0 = rep_n; f0 = ferr_n;
        send_frames(mk_frame(8'h12, 1'b1), IDLE_FRAME, 1, 1'b0);
        send_frames(mk_frame(8'h34, 1'b1), IDLE_FRAME, 0, 1'b0);
        repeat (18 * OVS) @(negedge clk);
        check("t3_busy_before_expiry", {31'h0, busy}, 1);
        check("t3_no_repeat_yet", rep_n - p0, 0);
        repeat (4 * OVS) @(negedge clk);
        check("t3_repeat", rep_n - p0, 1);
        check("t3_busy_after", {31'h0, busy}, 0);
        check("t3_no_accept", acc_n - a0, 0);
        check("t3_no_frame_err", ferr_n - f0, 0);
        check("t3_rx_count", rx_n - r0, 2);

        // Test 4: 10-clk start glitch on com1
        r0 = rx_n; p0 = rep_n;
        com1 = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_busy_on_edge", {31'h0, busy}, 1);
        repeat (5) @(negedge clk);
        com1 = 1'b1;
        repeat (OVS / 2 + 3 - 10) @(negedge clk);
        check("t4_busy_cleared", {31'h0, busy}, 0);
        check("t4_no_rdy", rx_n - r0, 0);
        check("t4_no_repeat", rep_n - p0, 0);
        repeat (OVS) @(negedge clk);

        // Test 5: simultaneous start, com2 garbage
        r0 = rx_n; a0 = acc_n; p0 = rep_n; f0 = ferr_n;
        for (int i = 0; i < 4; i++) send_frames(mk_frame(ccw5[i], 1'b1), mk_frame(gar5[i], 1'b0), 1, 1'b0);
        check("t5_chan", {31'h0, chan}, 0);
        check("t5_rx_count", rx_n - r0, 4);
        check_bytes("t5", r0, ccw5);
        check("t5_accepted", acc_n - a0, 1);
        check("t5_no_repeat", rep_n - p0, 0);
        check("t5_no_frame_err", ferr_n - f0, 0);

        // Test 6: enable dropped mid byte 2
        send_frames(mk_frame(8'h66, 1'b1), IDLE_FRAME, 1, 1'b0);
        fr = mk_frame(8'h77, 1'b1);
        for (int i = 0; i < 5; i++) drive_bit(fr[i], 1'b1, 1'b0);
        r0 = rx_n; a0 = acc_n; p0 = rep_n; f0 = ferr_n;
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_busy_dropped", {31'h0, busy}, 0);
        for (int i = 5; i < 11; i++) drive_bit(fr[i], 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0);
        check("t6_abort_no_rdy", rx_n - r0, 0);
        check("t6_abort_no_accept", acc_n - a0, 0);
        check("t6_abort_no_repeat", rep_n - p0, 0);
        check("t6_abort_no_frame_err", ferr_n - f0, 0);
        check("t6_q_held", {24'h0, q}, 32'h66);
        en = 1'b1;
        repeat (OVS) @(negedge clk);
        for (int i = 0; i < 4; i++) send_frames(mk_frame(ccw6[i], 1'b1), IDLE_FRAME, 1, 1'b0);
        check("t6_rx_count", rx_n - r0, 4);
        check_bytes("t6", r0, ccw6);
        check("t6_accepted", acc_n - a0, 1);

`ifdef HSI_RX_MAJORITY_EN
        // Test 7: 1-clk glitch at every bit centre is voted out
        r0 = rx_n; a0 = acc_n; p0 = rep_n;
        for (int i = 0; i < 4; i++) send_frames(mk_frame(ccw7[i], 1'b1), IDLE_FRAME, 1, 1'b1);
        check("t7_rx_count", rx_n - r0, 4);
        check_bytes("t7", r0, ccw7);
        check("t7_accepted", acc_n - a0, 1);
        check("t7_no_repeat", rep_n - p0, 0);
`endif

        // Test 8: reset in the middle of a byte on com2
        fr = mk_frame(8'h3E, 1'b1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, fr[i], 1'b0);
        check("t8_busy_mid_byte", {31'h0, busy}, 1);
        check("t8_chan_locked", {31'h0, chan}, 1);
        rst = 1'b1;
        com2 = 1'b1;
        #1;
        check("t8_reset_busy", {31'h0, busy}, 0);
        check("t8_reset_chan", {31'h0, chan}, 0);
        check("t8_reset_q", {24'h0, q}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (OVS) @(negedge clk);
        check("t8_idle_after_reset", {31'h0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
